// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the UART boot loader.
//   load_state_e : framing FSM states
//   uart_state_e : UART receiver states
//   HDR_BYTE_DEFAULT : default frame start marker
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE
    } load_state_e;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_e;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   rx         : serial input, idle high, asynchronous to clk
//   byte_valid : one-cycle pulse, byte_data holds the received byte
//   byte_data  : last received byte
//   fe         : one-cycle pulse on a zero stop bit (byte discarded)
module prog_loader_uart_rx
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       fe
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta, rx_sync, rx_prev;
    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          fe_q, fe_d;

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign fe         = fe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            U_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_sync) state_d = U_START;
            end
            U_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // Line back high at mid start bit: glitch, not a start.
                    state_d = rx_sync ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = U_STOP;
                end
            end
            U_STOP: begin
                // Sampled mid stop bit; idling from here re-arms for the next start edge.
                if (cnt_q == BIT_LAST) begin
                    state_d = U_IDLE;
                    valid_d = rx_sync;
                    fe_d    = !rx_sync;
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// UART boot loader: receives A5, LEN_lo, LEN_hi, then 4*LEN little-endian bytes,
// and writes each assembled word into instruction memory.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   rx         : UART serial input
//   imem_we    : one-cycle instruction memory write strobe
//   imem_addr  : word address of imem_wdata
//   imem_wdata : assembled instruction word
//   cpu_hold   : keeps the core in reset while high
//   done       : image fully written
//   err        : sticky framing / oversize error
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 8,
    parameter logic [7:0]  HDR_BYTE     = HDR_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    logic       byte_valid, fe;
    logic [7:0] byte_data;

    prog_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .fe        (fe)
    );

    load_state_e       state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       n_words;

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;
    assign n_words    = {byte_data, len_lo_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            widx_q   <= '0;
            lane_q   <= '0;
            asm_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            widx_q   <= widx_d;
            lane_q   <= lane_d;
            asm_q    <= asm_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        widx_d   = widx_q;
        lane_d   = lane_q;
        asm_d    = asm_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        if (fe) begin
            err_d = 1'b1;
            // A broken frame abandons the image; idle/done keep their state.
            if (state_q != S_IDLE && state_q != S_DONE) state_d = S_IDLE;
        end else if (byte_valid) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (byte_data == HDR_BYTE) begin
                        state_d = S_LEN0;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                S_LEN0: begin
                    len_lo_d = byte_data;
                    state_d  = S_LEN1;
                end
                S_LEN1: begin
                    len_d = n_words;
                    if (n_words == 16'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else if (32'(n_words) > (32'd1 << ADDR_W)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        widx_d  = '0;
                        lane_d  = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    lane_d = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: asm_d[7:0]   = byte_data;
                        2'd1: asm_d[15:8]  = byte_data;
                        2'd2: asm_d[23:16] = byte_data;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {byte_data, asm_q};
                            addr_d  = widx_q;
                            widx_d  = widx_q + 1'b1;
                            if (32'(widx_q) == 32'(len_q) - 32'd1) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                hold_d  = 1'b0;
                            end
                        end
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with CLKS_PER_BIT=4, ADDR_W=4.
module tb_prog_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold, done, err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  tx[$];
    int          base;

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .HDR_BYTE    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_a(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] wr_d(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_tx();
        foreach (tx[i]) send_byte(tx[i], 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic two-word image
        base = wr_data.size();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h85, 8'hA5, 8'h00};
        send_tx();
        check("basic_nwr", 32'(wr_data.size() - base), 32'd2);
        check("basic_a0", wr_a(base), 32'd0);
        check("basic_d0", wr_d(base), 32'h0010_0513);
        check("basic_a1", wr_a(base + 1), 32'd1);
        check("basic_d1", wr_d(base + 1), 32'h00A5_85B3);
        check("basic_addr_hold", 32'(imem_addr), 32'd1);
        check("basic_done", 32'(done), 32'd1);
        check("basic_hold", 32'(cpu_hold), 32'd0);
        check("basic_err", 32'(err), 32'd0);

        // Noise while done is ignored; a header reasserts hold
        tx = '{8'h00, 8'hFF, 8'h13};
        send_tx();
        check("noise_done", 32'(done), 32'd1);
        check("noise_hold", 32'(cpu_hold), 32'd0);
        base = wr_data.size();
        tx = '{8'hA5};
        send_tx();
        check("hdr_hold", 32'(cpu_hold), 32'd1);
        check("hdr_done", 32'(done), 32'd0);
        tx = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_tx();
        check("noise_nwr", 32'(wr_data.size() - base), 32'd1);
        check("noise_a0", wr_a(base), 32'd0);
        check("noise_d0", wr_d(base), 32'hDEAD_BEEF);
        check("noise_done2", 32'(done), 32'd1);

        // Zero length after reset, with noise from idle first
        do_reset();
        base = wr_data.size();
        tx = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00};
        send_tx();
        check("zero_nwr", 32'(wr_data.size() - base), 32'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_hold", 32'(cpu_hold), 32'd0);

        // Full capacity: N = 2^ADDR_W = 16 accepted
        do_reset();
        base = wr_data.size();
        tx = '{8'hA5, 8'h10, 8'h00};
        foreach (tx[i]) send_byte(tx[i], 1'b1);
        for (int i = 0; i < 16; i++) send_word(32'hC0DE_0000 | 32'(i * 17));
        repeat (10) @(negedge clk);
        check("full_nwr", 32'(wr_data.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("full_addr", wr_a(base + i), 32'(i));
            check("full_data", wr_d(base + i), 32'hC0DE_0000 | 32'(i * 17));
        end
        check("full_done", 32'(done), 32'd1);
        check("full_err", 32'(err), 32'd0);

        // Oversize N = 17
        do_reset();
        base = wr_data.size();
        tx = '{8'hA5, 8'h11, 8'h00};
        send_tx();
        check("over_err", 32'(err), 32'd1);
        check("over_hold", 32'(cpu_hold), 32'd1);
        check("over_done", 32'(done), 32'd0);
        check("over_state", 32'(dut.state_q), 32'(prog_loader_pkg::S_IDLE));
        check("over_nwr", 32'(wr_data.size() - base), 32'd0);

        // Framing error on the third byte of word 0
        do_reset();
        base = wr_data.size();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        foreach (tx[i]) send_byte(tx[i], 1'b1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        repeat (10) @(negedge clk);
        check("fe_err", 32'(err), 32'd1);
        check("fe_hold", 32'(cpu_hold), 32'd1);
        check("fe_nwr", 32'(wr_data.size() - base), 32'd0);
        tx = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_tx();
        check("fe_reload_nwr", 32'(wr_data.size() - base), 32'd1);
        check("fe_reload_a0", wr_a(base), 32'd0);
        check("fe_reload_d0", wr_d(base), 32'h1234_5678);
        check("fe_reload_done", 32'(done), 32'd1);
        check("fe_err_sticky", 32'(err), 32'd1);

        // Async reset mid-image after one word
        do_reset();
        base = wr_data.size();
        tx = '{8'hA5, 8'h02, 8'h00};
        foreach (tx[i]) send_byte(tx[i], 1'b1);
        send_word(32'hCAFE_F00D);
        send_byte(8'h99, 1'b1);
        repeat (3) @(negedge clk);
        check("mid_wr", wr_d(base), 32'hCAFE_F00D);
        #2 rst = 1'b0;
        #1;
        check("arst_wdata", imem_wdata, 32'd0);
        check("arst_hold", 32'(cpu_hold), 32'd1);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_state", 32'(dut.state_q), 32'(prog_loader_pkg::S_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        base = wr_data.size();
        tx = '{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hD0, 8'hAD, 8'hBA};
        send_tx();
        check("arst_nwr", 32'(wr_data.size() - base), 32'd1);
        check("arst_a0", wr_a(base), 32'd0);
        check("arst_d0", wr_d(base), 32'hBAAD_D00D);
        check("arst_done2", 32'(done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- UART boot loader: the writer side of the instruction memory that the RV32IC core fetches from.
- Receives a framed program image over a serial line and assembles little-endian 32-bit words.
- Writes each word into instruction memory through a write port.
- Holds the core in reset until the image is complete, then releases it.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4
ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
HDR_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
rx  input  1  UART serial input, idle high, asynchronous to clk
imem_we  output  1  one-cycle write strobe to instruction memory
imem_addr  output  ADDR_W  word address of imem_wdata
imem_wdata  output  32  assembled instruction word
cpu_hold  output  1  high keeps the core in reset
done  output  1  image fully written
err  output  1  sticky error: framing error or oversize length

Behaviour:
- Reset (rst low, async) sets: imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0; FSM goes to S_IDLE.
- Reset asserted mid-image abandons the image. Words already written are not erased.
- UART rx:
  - rx passes through a 2-flop synchroniser.
  - A falling edge in idle starts a bit.
  - Start bit is re-checked at half-bit (CLKS_PER_BIT/2). If rx is high there, it is a glitch: return to idle, no byte.
  - 8 data bits are sampled mid-bit, LSB first, then 1 stop bit.
  - Stop bit = 0: framing error, byte discarded, fe pulses 1 cycle.
  - Otherwise byte_valid pulses 1 cycle with the byte.
  - Receiver re-arms for the next start bit during the stop bit's second half.
- Frame format: HDR_BYTE, LEN_lo, LEN_hi (N = 16-bit word count), then 4*N data bytes. Words are little-endian (first byte = bits 7:0).
- FSM states:
  - S_IDLE: bytes other than HDR_BYTE are ignored. HDR_BYTE: go to S_LEN0, set cpu_hold=1, done=0.
  - S_LEN0: latch LEN_lo, go to S_LEN1.
  - S_LEN1: latch LEN_hi.
    - N=0: go to S_DONE.
    - N > 2^ADDR_W: err=1, go to S_IDLE.
    - Otherwise: word counter=0, byte lane=0, go to S_DATA.
  - S_DATA: each byte shifts into lane 0..3. On lane 3:
    - imem_wdata is registered and imem_we=1 for exactly one cycle, on the cycle after byte_valid.
    - imem_addr = word index, starting at 0 and incrementing after each write. It holds its last value between writes.
    - When the word index reaches N-1, go to S_DONE after the write.
  - S_DONE: done=1, cpu_hold=0. A new HDR_BYTE re-enters S_LEN0 and reasserts cpu_hold the next cycle.
- Framing error in any state except S_IDLE/S_DONE: err=1, return to S_IDLE, cpu_hold stays 1, any partial word is dropped.
- err is sticky and clears only on reset.
- Framing error in S_IDLE/S_DONE sets err but does not change state.
- Word index never wraps: the oversize check guarantees N ≤ 2^ADDR_W.
- Throughput: one imem write per 40 bit-times; no back-pressure; memory write is single-cycle.

Decomposition:
- Shared package holds:
  - FSM state enum (S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE).
  - HDR_BYTE default.
  - UART state enum (U_IDLE, U_START, U_DATA, U_STOP).
- Sub-module uart_rx (clk, rst, rx → byte_valid, byte_data[7:0], fe) with parameter CLKS_PER_BIT.
- prog_loader holds the framing FSM, the 32-bit assembly register and the counters.

Test Plan:
- Basic image, CLKS_PER_BIT=4, ADDR_W=4. Send A5 02 00 13 05 10 00 B3 85 A5 00 → response:
  - imem_we pulses twice: addr0=32'h00100513, addr1=32'h00A585B3.
  - Then done=1, cpu_hold=0, err=0.
- Noise before the header. Send 00 FF 13, then A5 01 00 EF BE AD DE → response:
  - leading bytes ignored.
  - single write addr0=32'hDEADBEEF, done=1.
- Zero length. Send A5 00 00 → response: done=1, cpu_hold=0, no imem_we.
- Oversize, ADDR_W=4. Send A5 11 00 (N=17) → response: err=1, cpu_hold=1, FSM in S_IDLE, no writes.
- Framing error. Send a data byte with stop bit 0 as the 3rd data byte of word 0 → response:
  - err=1, no write for that word, cpu_hold=1.
  - A subsequent valid frame still loads, and err remains 1.
- Async reset pulse mid-S_DATA after 1 word → response:
  - all outputs return to reset values immediately.
  - A new frame A5 01 00 … writes at addr0.
